// File: rtl/reg_file_dumper.sv
// Sequential register-file reader: walks an inclusive address range and streams
// each captured value with its address over a valid/ready interface.
module reg_file_dumper #(
    parameter int unsigned W = 8,
    parameter int unsigned D = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic         i_abort,
    input  logic [D-1:0] i_first_addr,
    input  logic [D-1:0] i_last_addr,
    output logic [D-1:0] o_raddr,
    input  logic [W-1:0] i_rdata,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_out_data,
    output logic [D-1:0] o_out_addr,
    output logic         o_busy,
    output logic         o_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [D-1:0]   r_ptr, w_ptr_nxt;
    logic [D-1:0]   r_first, w_first_nxt;
    logic [D-1:0]   r_last, w_last_nxt;
    logic           r_valid, w_valid_nxt;
    logic [W-1:0]   r_data, w_data_nxt;
    logic [D-1:0]   r_addr, w_addr_nxt;
    logic           r_busy, w_busy_nxt;
    logic           r_done, w_done_nxt;

    // State and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_first <= '0;
            r_last  <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_first <= w_first_nxt;
            r_last  <= w_last_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_addr  <= w_addr_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_first_nxt = r_first;
        w_last_nxt  = r_last;
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_addr_nxt  = r_addr;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (i_start && !i_abort) begin
                    w_first_nxt = i_first_addr;
                    w_last_nxt  = i_last_addr;
                    w_ptr_nxt   = i_first_addr;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_data_nxt  = i_rdata;
                w_addr_nxt  = r_ptr;
                w_valid_nxt = 1'b1;
                w_busy_nxt  = 1'b1;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (r_valid && i_out_ready) begin
                    w_valid_nxt = 1'b0;
                    if (r_ptr == r_last) begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_ptr_nxt   = r_ptr + D'(1);
                        w_state_nxt = S_READ;
                    end
                end
            end
            S_DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Abort overrides everything, including a coincident handshake
        if (i_abort) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = r_ptr;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
        end
    end

    assign o_raddr     = r_ptr;
    assign o_out_valid = r_valid;
    assign o_out_data  = r_data;
    assign o_out_addr  = r_addr;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_reg_file_dumper.sv
// Self-checking bench for reg_file_dumper: directed scenarios plus randomized
// dumps checked against an expected beat list built from the address range.
module tb_reg_file_dumper;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;
    localparam int unsigned N = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         i_start = 1'b0;
    logic         i_abort = 1'b0;
    logic [D-1:0] i_first = '0;
    logic [D-1:0] i_last = '0;
    logic [D-1:0] o_raddr;
    logic [W-1:0] w_rdata;
    logic         o_valid;
    logic         i_ready = 1'b0;
    logic [W-1:0] o_data;
    logic [D-1:0] o_addr;
    logic         o_busy;
    logic         o_done;

    logic [W-1:0] rf [N];

    int n_checks = 0;
    int n_errors = 0;

    assign w_rdata = rf[o_raddr];

    always #5 clk = ~clk;

    reg_file_dumper #(.W(W), .D(D)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_first_addr (i_first),
        .i_last_addr  (i_last),
        .o_raddr      (o_raddr),
        .i_rdata      (w_rdata),
        .o_out_valid  (o_valid),
        .i_out_ready  (i_ready),
        .o_out_data   (o_data),
        .o_out_addr   (o_addr),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One dump from first to last; stall0 holds ready low on the first beat
    // (and overwrites that register mid-stall); abort_beat aborts on that handshake.
    task automatic run_dump(input logic [D-1:0] first, input logic [D-1:0] last,
                            input int ready_pct, input int stall0, input int abort_beat);
        logic [D-1:0] exp_addr[$];
        logic [W-1:0] exp_data[$];
        logic [D-1:0] a;
        int  n, beat, cyc, stall_left;
        bit  got_done, aborted, seen_valid, rdy;

        n = int'(D'(last - first)) + 1;
        for (int k = 0; k < n; k++) begin
            a = first + D'(k);
            exp_addr.push_back(a);
            exp_data.push_back(rf[a]);
        end

        @(negedge clk);
        i_start = 1'b1;
        i_first = first;
        i_last  = last;
        i_ready = 1'b0;
        cyc = 0; beat = 0; stall_left = stall0;
        got_done = 1'b0; aborted = 1'b0; seen_valid = 1'b0;

        while (!got_done && !aborted && cyc < 400) begin
            @(negedge clk);
            cyc++;
            i_start = 1'b0;
            i_abort = 1'b0;
            if (o_done) begin
                got_done = 1'b1;
                check_eq("beats_before_done", 32'(beat), 32'(n));
                check_eq("busy_in_done", 32'(o_busy), 32'd0);
                check_eq("valid_in_done", 32'(o_valid), 32'd0);
                if (ready_pct == 100 && stall0 == 0)
                    check_eq("done_cycle", 32'(cyc), 32'(2 * n + 1));
            end else if (o_valid) begin
                if (!seen_valid) begin
                    check_eq("first_valid_latency", 32'(cyc), 32'd2);
                    seen_valid = 1'b1;
                end
                check_eq("busy_in_send", 32'(o_busy), 32'd1);
                if (beat < n) begin
                    check_eq("out_addr", 32'(o_addr), 32'(exp_addr[beat]));
                    check_eq("out_data", 32'(o_data), 32'(exp_data[beat]));
                end else begin
                    check_eq("extra_beat", 32'(beat), 32'(n - 1));
                end
                if (stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                    if (stall_left == stall0 - 2) rf[exp_addr[0]] = 8'hAA;
                end else begin
                    rdy = ($urandom_range(99) < 32'(ready_pct));
                end
                i_ready = rdy;
                if (rdy) begin
                    if (beat == abort_beat) begin
                        i_abort = 1'b1;
                        aborted = 1'b1;
                    end
                    beat++;
                end
            end else begin
                check_eq("busy_in_read", 32'(o_busy), 32'd1);
                i_ready = 1'($urandom_range(1));
            end
            if (!got_done && cyc == 3) begin
                i_start = 1'b1;
                i_first = D'($urandom);
                i_last  = D'($urandom);
            end
        end

        if (aborted) begin
            @(negedge clk);
            i_start = 1'b0;
            i_abort = 1'b0;
            check_eq("abort_valid", 32'(o_valid), 32'd0);
            check_eq("abort_busy", 32'(o_busy), 32'd0);
            check_eq("abort_done", 32'(o_done), 32'd0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check_eq("abort_no_done", 32'(o_done), 32'd0);
                check_eq("abort_idle_busy", 32'(o_busy), 32'd0);
            end
        end else begin
            check_eq("dump_done_seen", 32'(got_done), 32'd1);
            i_start = 1'b0;
            @(negedge clk);
            check_eq("done_one_cycle", 32'(o_done), 32'd0);
            check_eq("idle_busy", 32'(o_busy), 32'd0);
        end
        i_ready = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < N; k++) rf[k] = '0;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_raddr", 32'(o_raddr), 32'd0);
        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_data", 32'(o_data), 32'd0);
        check_eq("rst_addr", 32'(o_addr), 32'd0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_done", 32'(o_done), 32'd0);
        rst_n = 1'b1;

        // Full dump
        rf[0] = 8'd30;
        rf[2] = 8'd5;
        run_dump(4'd0, 4'd15, 100, 0, -1);

        // Backpressure on the first beat, register overwritten while stalled
        rf[3] = 8'h33;
        run_dump(4'd2, 4'd3, 100, 5, -1);
        check_eq("rf_overwritten", 32'(rf[2]), 32'hAA);

        // Wrap-around walk
        rf[14] = 8'h0E; rf[15] = 8'h0F; rf[1] = 8'h11;
        run_dump(4'd14, 4'd1, 100, 0, -1);

        // Single beat
        rf[7] = 8'h5A;
        run_dump(4'd7, 4'd7, 100, 0, -1);

        // Abort coinciding with the third handshake
        run_dump(4'd0, 4'd15, 100, 0, 2);

        // Asynchronous reset in the middle of SEND
        @(negedge clk);
        i_start = 1'b1; i_first = 4'd0; i_last = 4'd15; i_ready = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        check_eq("pre_reset_valid", 32'(o_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 32'(o_valid), 32'd0);
        check_eq("async_rst_busy", 32'(o_busy), 32'd0);
        check_eq("async_rst_raddr", 32'(o_raddr), 32'd0);
        check_eq("async_rst_done", 32'(o_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rf[4] = 8'hC3;
        run_dump(4'd4, 4'd4, 100, 0, -1);

        // Randomized dumps
        for (int t = 0; t < 10; t++) begin
            for (int k = 0; k < N; k++) rf[k] = W'($urandom);
            run_dump(D'($urandom), D'($urandom), (t % 2 == 0) ? 100 : 60, 0,
                     (t == 7) ? 1 : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
